// File: rtl/mem_stage_access.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : mem_stage_access                                              |
// | Purpose  : MEM pipeline stage bus master. Turns a load/store request     |
// |            from the EX/MEM register into a single bus transfer with      |
// |            big-endian lane steering, load extension and a bus timeout.   |
// | Ports    : clk, rst (async, active-low)                                  |
// |            MemRead_in, MemWrite_in, BHW_in[1:0], DataMemExtendSign_in,   |
// |            ALUResult_in[31:0] (address), ReadData2_in[31:0] (store data) |
// |            mem_req, mem_we, mem_addr[31:0], mem_wdata[31:0], mem_be[3:0],|
// |            mem_ack, mem_rdata[31:0]                                      |
// |            LoadData_out[31:0], Stall_out, Misaligned_out, BusError_out   |
// | Options  : MEM_ALIGN_CHECK_EN - reject misaligned accesses and flag them |
// |            on Misaligned_out; otherwise low address bits are ignored.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mem_stage_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [1:0]  BHW_in,
    input  logic        DataMemExtendSign_in,
    input  logic [31:0] ALUResult_in,
    input  logic [31:0] ReadData2_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] LoadData_out,
    output logic        Stall_out,
    output logic        Misaligned_out,
    output logic        BusError_out
);

    localparam logic [1:0] c_SZ_WORD      = 2'd0;
    localparam logic [1:0] c_SZ_HALF      = 2'd1;
    localparam logic [1:0] c_SZ_BYTE      = 2'd2;
    // Count value seen during the 16th un-acked REQ cycle
    localparam logic [4:0] c_TIMEOUT_LAST = 5'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic [31:0] r_addr;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic        r_sign;
    logic [4:0]  r_timeout;
    logic [31:0] r_loadData;
    logic        r_misaligned;
    logic        r_busError;

    logic        w_req;
    logic        w_fault;
    logic        w_accept;
    logic        w_timeout;
    logic [1:0]  w_size;
    logic [1:0]  w_off;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byteLane;
    logic [15:0] w_halfLane;
    logic [31:0] w_loadExt;

    // ---------------- request decode ----------------
    assign w_req  = MemRead_in | MemWrite_in;
    assign w_size = (BHW_in == 2'b11) ? c_SZ_WORD : BHW_in;

`ifdef MEM_ALIGN_CHECK_EN
    logic w_misalign;
    assign w_misalign = ((w_size == c_SZ_HALF) && ALUResult_in[0]) ||
                        ((w_size == c_SZ_WORD) && (ALUResult_in[1:0] != 2'b00));
    assign w_fault    = w_misalign;
`else
    assign w_fault    = 1'b0;
`endif

    // Offset is forced aligned to the access size, so without the check
    // a misaligned address simply lands on the containing half/word.
    always_comb begin
        w_off   = 2'b00;
        w_be    = 4'b1111;
        w_wdata = ReadData2_in;
        case (w_size)
            c_SZ_HALF: begin
                w_off   = {ALUResult_in[1], 1'b0};
                w_be    = ALUResult_in[1] ? 4'b0011 : 4'b1100;
                w_wdata = {2{ReadData2_in[15:0]}};
            end
            c_SZ_BYTE: begin
                w_off   = ALUResult_in[1:0];
                w_be    = 4'b1000 >> ALUResult_in[1:0];
                w_wdata = {4{ReadData2_in[7:0]}};
            end
            default: ;
        endcase
    end

    // ---------------- read lane select / extend (big-endian) ----------------
    always_comb begin
        case (r_off)
            2'd0:    w_byteLane = mem_rdata[31:24];
            2'd1:    w_byteLane = mem_rdata[23:16];
            2'd2:    w_byteLane = mem_rdata[15:8];
            default: w_byteLane = mem_rdata[7:0];
        endcase
        w_halfLane = r_off[1] ? mem_rdata[15:0] : mem_rdata[31:16];
        case (r_size)
            c_SZ_HALF: w_loadExt = {{16{r_sign & w_halfLane[15]}}, w_halfLane};
            c_SZ_BYTE: w_loadExt = {{24{r_sign & w_byteLane[7]}}, w_byteLane};
            default:   w_loadExt = mem_rdata;
        endcase
    end

    // ---------------- FSM next-state / outputs ----------------
    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        w_timeout   = 1'b0;
        mem_req     = 1'b0;
        Stall_out   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req && !w_fault) begin
                    w_accept    = 1'b1;
                    Stall_out   = 1'b1;
                    w_stateNext = REQ;
                end
            end
            REQ: begin
                mem_req   = 1'b1;
                Stall_out = 1'b1;
                if (mem_ack) begin
                    w_stateNext = DONE;
                end else if (r_timeout == c_TIMEOUT_LAST) begin
                    w_timeout   = 1'b1;
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // ---------------- state and datapath registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_addr       <= 32'd0;
            r_we         <= 1'b0;
            r_be         <= 4'd0;
            r_wdata      <= 32'd0;
            r_size       <= c_SZ_WORD;
            r_off        <= 2'd0;
            r_sign       <= 1'b0;
            r_timeout    <= 5'd0;
            r_loadData   <= 32'd0;
            r_misaligned <= 1'b0;
            r_busError   <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_busError   <= w_timeout;
            r_misaligned <= (r_state == IDLE) && w_req && w_fault;
            if (w_accept) begin
                r_addr    <= {ALUResult_in[31:2], 2'b00};
                r_we      <= MemWrite_in;    // read+write collapses to write
                r_be      <= w_be;
                r_wdata   <= w_wdata;
                r_size    <= w_size;
                r_off     <= w_off;
                r_sign    <= DataMemExtendSign_in;
                r_timeout <= 5'd0;
            end
            if ((r_state == REQ) && !mem_ack) begin
                r_timeout <= r_timeout + 5'd1;
            end
            if ((r_state == REQ) && mem_ack && !r_we) begin
                r_loadData <= w_loadExt;
            end
        end
    end

    assign mem_we         = r_we;
    assign mem_addr       = r_addr;
    assign mem_wdata      = r_wdata;
    assign mem_be         = r_be;
    assign LoadData_out   = r_loadData;
    assign Misaligned_out = r_misaligned;
    assign BusError_out   = r_busError;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_access.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_stage_access                                           |
// | Purpose  : Directed self-checking bench for mem_stage_access.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mem_stage_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead_in, MemWrite_in;
    logic [1:0]  BHW_in;
    logic        DataMemExtendSign_in;
    logic [31:0] ALUResult_in, ReadData2_in;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] LoadData_out;
    logic        Stall_out, Misaligned_out, BusError_out;

    always #5 clk = ~clk;

    mem_stage_access u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .MemRead_in          (MemRead_in),
        .MemWrite_in         (MemWrite_in),
        .BHW_in              (BHW_in),
        .DataMemExtendSign_in(DataMemExtendSign_in),
        .ALUResult_in        (ALUResult_in),
        .ReadData2_in        (ReadData2_in),
        .mem_req             (mem_req),
        .mem_we              (mem_we),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .mem_be              (mem_be),
        .mem_ack             (mem_ack),
        .mem_rdata           (mem_rdata),
        .LoadData_out        (LoadData_out),
        .Stall_out           (Stall_out),
        .Misaligned_out      (Misaligned_out),
        .BusError_out        (BusError_out)
    );

    int nVec        = 0;
    int nMiscompare = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        if (obs !== exp) begin
            nMiscompare++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Captured results of the most recent access
    int          gotStall, gotReq;
    logic [31:0] gotAddr, gotWdata;
    logic [3:0]  gotBe;
    logic        gotWe, gotBusErr, gotDoneStall;

    // Issue one request from IDLE; ack it during the ackAt-th REQ cycle
    // (0 = never). Returns sampled at the negedge where DONE is observed.
    task automatic doAccess(input logic rd, input logic wr, input logic [1:0] bhw,
                            input logic sgn, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int ackAt);
        bit saw = 0;
        bit fin = 0;
        int cyc = 0;
        gotStall = 0;
        gotReq   = 0;
        @(negedge clk);
        MemRead_in           = rd;
        MemWrite_in          = wr;
        BHW_in               = bhw;
        DataMemExtendSign_in = sgn;
        ALUResult_in         = addr;
        ReadData2_in         = wdata;
        mem_rdata            = rdata;
        while (!fin && cyc < 40) begin
            #1;
            if (saw && !mem_req) begin
                fin          = 1;
                mem_ack      = 1'b0;
                gotBusErr    = BusError_out;
                gotDoneStall = Stall_out;
            end else begin
                gotStall += int'(Stall_out);
                gotReq   += int'(mem_req);
                if (mem_req && !saw) begin
                    saw         = 1;
                    gotAddr     = mem_addr;
                    gotWdata    = mem_wdata;
                    gotBe       = mem_be;
                    gotWe       = mem_we;
                    MemRead_in  = 1'b0;
                    MemWrite_in = 1'b0;
                end
                mem_ack = mem_req && (gotReq == ackAt);
                cyc++;
                @(negedge clk);
            end
        end
        if (!fin) begin
            chk("accessBound", 32'd0, 32'd1);
            mem_ack     = 1'b0;
            MemRead_in  = 1'b0;
            MemWrite_in = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0;
        MemRead_in = 0; MemWrite_in = 0; BHW_in = 0; DataMemExtendSign_in = 0;
        ALUResult_in = 0; ReadData2_in = 0; mem_ack = 0; mem_rdata = 0;
        #12;
        chk("rst_req",   {31'd0, mem_req},        32'd0);
        chk("rst_we",    {31'd0, mem_we},         32'd0);
        chk("rst_addr",  mem_addr,                32'd0);
        chk("rst_wdata", mem_wdata,               32'd0);
        chk("rst_be",    {28'd0, mem_be},         32'd0);
        chk("rst_load",  LoadData_out,            32'd0);
        chk("rst_mis",   {31'd0, Misaligned_out}, 32'd0);
        chk("rst_berr",  {31'd0, BusError_out},   32'd0);
        chk("rst_stall", {31'd0, Stall_out},      32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Word read, ack on 2nd REQ cycle
        doAccess(1, 0, 2'b00, 0, 32'h100, 32'h0, 32'hDEADBEEF, 2);
        chk("wr_addr",  gotAddr,             32'h100);
        chk("wr_be",    {28'd0, gotBe},      32'hF);
        chk("wr_we",    {31'd0, gotWe},      32'd0);
        chk("wr_stall", gotStall,            32'd3);
        chk("wr_reqs",  gotReq,              32'd2);
        chk("wr_load",  LoadData_out,        32'hDEADBEEF);
        chk("wr_dstl",  {31'd0, gotDoneStall}, 32'd0);

        // Byte reads, offset 3, signed then unsigned
        doAccess(1, 0, 2'b10, 1, 32'h103, 32'h0, 32'h123456F0, 1);
        chk("bs_addr", gotAddr,        32'h100);
        chk("bs_be",   {28'd0, gotBe}, 32'h1);
        chk("bs_load", LoadData_out,   32'hFFFFFFF0);
        doAccess(1, 0, 2'b10, 0, 32'h103, 32'h0, 32'h123456F0, 1);
        chk("bu_load", LoadData_out,   32'h000000F0);

        // Halfword write at offset 2
        doAccess(0, 1, 2'b01, 0, 32'h202, 32'h0000ABCD, 32'h11112222, 1);
        chk("hw_we",    {31'd0, gotWe},  32'd1);
        chk("hw_be",    {28'd0, gotBe},  32'h3);
        chk("hw_wdata", gotWdata,        32'hABCDABCD);
        chk("hw_addr",  gotAddr,         32'h200);
        chk("hw_load",  LoadData_out,    32'h000000F0);

        // Signed halfword read at offset 0
        doAccess(1, 0, 2'b01, 1, 32'h200, 32'h0, 32'h80011234, 3);
        chk("hr_be",   {28'd0, gotBe}, 32'hC);
        chk("hr_load", LoadData_out,   32'hFFFF8001);
        chk("hr_stl",  gotStall,       32'd4);

        // Size code 11 behaves as word
        doAccess(1, 0, 2'b11, 1, 32'h104, 32'h0, 32'h01234567, 1);
        chk("w3_be",   {28'd0, gotBe}, 32'hF);
        chk("w3_addr", gotAddr,        32'h104);
        chk("w3_load", LoadData_out,   32'h01234567);

        // Signed byte read at offset 1
        doAccess(1, 0, 2'b10, 1, 32'h301, 32'h0, 32'h11803344, 1);
        chk("b1_be",   {28'd0, gotBe}, 32'h4);
        chk("b1_load", LoadData_out,   32'hFFFFFF80);

        // Read and write together -> byte write only
        doAccess(1, 1, 2'b10, 0, 32'h302, 32'h0000007E, 32'hFFFFFFFF, 1);
        chk("rw_we",    {31'd0, gotWe}, 32'd1);
        chk("rw_be",    {28'd0, gotBe}, 32'h2);
        chk("rw_wdata", gotWdata,       32'h7E7E7E7E);
        chk("rw_load",  LoadData_out,   32'hFFFFFF80);

        // Timeout: ack never comes
        doAccess(1, 0, 2'b00, 0, 32'h400, 32'h0, 32'h55555555, 0);
        chk("to_reqs", gotReq,                 32'd16);
        chk("to_berr", {31'd0, gotBusErr},     32'd1);
        chk("to_dstl", {31'd0, gotDoneStall},  32'd0);
        chk("to_load", LoadData_out,           32'hFFFFFF80);
        @(negedge clk); #1;
        chk("to_berr_clr", {31'd0, BusError_out}, 32'd0);
        chk("to_req_clr",  {31'd0, mem_req},      32'd0);

`ifdef MEM_ALIGN_CHECK_EN
        @(negedge clk);
        MemRead_in = 1; BHW_in = 2'b00; DataMemExtendSign_in = 0; ALUResult_in = 32'h101;
        #1;
        chk("ma_stall", {31'd0, Stall_out}, 32'd0);
        chk("ma_req0",  {31'd0, mem_req},   32'd0);
        @(negedge clk); #1;
        chk("ma_flag",  {31'd0, Misaligned_out}, 32'd1);
        chk("ma_req1",  {31'd0, mem_req},        32'd0);
        MemRead_in = 0;
        @(negedge clk); #1;
        chk("ma_flag_clr", {31'd0, Misaligned_out}, 32'd0);
        chk("ma_req2",     {31'd0, mem_req},        32'd0);
`else
        doAccess(1, 0, 2'b00, 0, 32'h101, 32'h0, 32'hCAFEF00D, 1);
        chk("ma_addr", gotAddr,      32'h100);
        chk("ma_load", LoadData_out, 32'hCAFEF00D);
        chk("ma_flag", {31'd0, Misaligned_out}, 32'd0);
        doAccess(1, 0, 2'b01, 0, 32'h203, 32'h0, 32'h12345678, 1);
        chk("mh_addr", gotAddr,        32'h200);
        chk("mh_be",   {28'd0, gotBe}, 32'h3);
        chk("mh_load", LoadData_out,   32'h00005678);
`endif

        // Reset in the middle of REQ, then a late ack
        @(negedge clk);
        MemRead_in = 1; BHW_in = 2'b00; DataMemExtendSign_in = 0; ALUResult_in = 32'h500;
        @(negedge clk); #1;
        chk("ar_inreq", {31'd0, mem_req}, 32'd1);
        MemRead_in = 0;
        #2 rst = 1'b0;
        #1;
        chk("ar_req",   {31'd0, mem_req},   32'd0);
        chk("ar_addr",  mem_addr,           32'd0);
        chk("ar_be",    {28'd0, mem_be},    32'd0);
        chk("ar_load",  LoadData_out,       32'd0);
        chk("ar_stall", {31'd0, Stall_out}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
        @(negedge clk); #1;
        chk("la_req",  {31'd0, mem_req},   32'd0);
        chk("la_stl",  {31'd0, Stall_out}, 32'd0);
        @(negedge clk); #1;
        chk("la_load", LoadData_out,       32'd0);
        chk("la_req2", {31'd0, mem_req},   32'd0);
        mem_ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiscompare);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage_access.md
MEM_STAGE_ACCESS -- requirements
Module: mem_stage_access

Interface
REQ-001 clk  in  1  single clock; all state changes on posedge clk.
REQ-002 rst  in  1  asynchronous, active-low reset; rst==0 forces reset state immediately, independent of clk.
REQ-003 MemRead_in, MemWrite_in  in  1 each  access request from EX/MEM stage register outputs.
REQ-004 BHW_in  in  2  access size: 00 word, 01 halfword, 10 byte, 11 treated as word.
REQ-005 DataMemExtendSign_in  in  1  load extension: 1 sign-extend, 0 zero-extend.
REQ-006 ALUResult_in  in  32  byte address; ReadData2_in  in  32  store data (right-justified).
REQ-007 mem_req  out  1; mem_we  out  1; mem_addr  out  32 (bits[1:0]==00); mem_wdata  out  32; mem_be  out  4  byte enables, bit3 = bits[31:24].
REQ-008 mem_ack  in  1  transfer complete; mem_rdata  in  32  valid when mem_ack==1.
REQ-009 LoadData_out  out  32  extended load result; Stall_out  out  1  hold upstream stages; Misaligned_out, BusError_out  out  1  sticky-for-one-cycle fault flags.

Function
REQ-010 Byte order SHALL be big-endian: offset 0 -> lane bits[31:24], offset 3 -> bits[7:0]; halfword offset 0 -> [31:16], offset 2 -> [15:0].
REQ-011 FSM states SHALL be IDLE, REQ, DONE; reset state IDLE.
REQ-012 IDLE: if MemWrite_in|MemRead_in (and not faulted per REQ-020), latch address, we, be, shifted wdata, size, sign; go REQ next edge.
REQ-013 MemRead_in and MemWrite_in both high SHALL execute as write only.
REQ-014 REQ: mem_req=1 with mem_addr/mem_we/mem_wdata/mem_be held stable from registers until mem_ack sampled 1; then go DONE.
REQ-015 On ack of a read, mem_rdata lane SHALL be selected, extended per latched sign/size, registered into LoadData_out.
REQ-016 DONE: mem_req=0, Stall_out=0 for exactly one cycle; return to IDLE next edge; LoadData_out holds until next read completes.
REQ-017 Stall_out SHALL be combinational: 1 in IDLE when a legal request is present, 1 throughout REQ, 0 otherwise; minimum 2 stall cycles per access.
REQ-018 Timeout counter (5-bit) SHALL clear on entry to REQ, increment each REQ cycle without ack; at 16 un-acked cycles: drop mem_req, pulse BusError_out one cycle, go DONE, LoadData_out unchanged.
REQ-019 Writes: mem_be 1111 word; 1100/0011 half; one-hot byte; mem_wdata SHALL replicate data into the addressed lane(s).
REQ-020 Misalignment (half with addr[0]==1, word with addr[1:0]!=00) SHALL be handled per Configuration.
REQ-021 Requests arriving while in REQ or DONE SHALL be ignored; upstream holds them by Stall_out/next IDLE.

Reset
REQ-022 On rst==0: state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, LoadData_out=0, Misaligned_out=0, BusError_out=0, counter 0.
REQ-023 Reset during REQ SHALL abort the access immediately; a mem_ack arriving after reset deassertion in IDLE SHALL be ignored.

Configuration
REQ-024 Macro MEM_ALIGN_CHECK_EN defined: misaligned request SHALL not issue mem_req, SHALL pulse Misaligned_out one cycle, Stall_out=0, stay IDLE.
REQ-025 Macro MEM_ALIGN_CHECK_EN undefined: no check; low address bits below access size ignored (forced aligned); Misaligned_out tied 0.

Verification
REQ-026 Word read addr 0x100, mem_rdata 0xDEADBEEF ack after 2 REQ cycles -> mem_addr 0x100, be 1111, LoadData_out 0xDEADBEEF, Stall_out high 3 cycles.
REQ-027 Byte read signed addr 0x103, rdata 0x123456F0 -> LoadData_out 0xFFFFFFF0; unsigned -> 0x000000F0.
REQ-028 Half write addr 0x202, ReadData2_in 0x0000ABCD -> mem_we 1, be 0011, mem_wdata 0xABCDABCD, LoadData_out unchanged.
REQ-029 Read with mem_ack never asserted -> mem_req drops after 16 cycles, BusError_out pulses once, Stall_out released.
REQ-030 Word read addr 0x101 with MEM_ALIGN_CHECK_EN -> no mem_req, Misaligned_out pulse; without macro -> mem_addr 0x100.
REQ-031 rst low mid-REQ -> all outputs zero asynchronously; late mem_ack after release causes no state change.
